// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer
// Read-side consumer of the 8-deep synchronous FIFO. Once the FIFO holds a
// full payload, it drains exactly PAYLOAD_LEN bytes and emits the frame
// SOF, LEN, payload..., CHECKSUM on a valid/ready byte stream.
// The FIFO read port is registered: read data appears one cycle after the
// edge that samples fifoRdEn, which is why every payload byte costs a
// RD_REQ + RD_WAIT pair before it can be presented.

module fifo_frame_packer #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    COUNT_WIDTH = 4,
  parameter int                    PAYLOAD_LEN = 4,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   resetN,
  output logic                   fifoRdEn,
  input  logic [DATA_WIDTH-1:0]  fifoRdData,
  input  logic                   fifoEmpty,
  input  logic [COUNT_WIDTH-1:0] fifoDataCount,
  output logic [DATA_WIDTH-1:0]  txData,
  output logic                   txValid,
  input  logic                   txReady,
  output logic                   txLast,
  output logic                   busy
);

  // Frame sequencing states
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR_SOF = 3'd1;
  localparam logic [2:0] HDR_LEN = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] PAYLOAD = 3'd5;
  localparam logic [2:0] CHKSUM  = 3'd6;

  localparam logic [COUNT_WIDTH-1:0] LEN_COUNT  = COUNT_WIDTH'(PAYLOAD_LEN);
  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(PAYLOAD_LEN - 1);
  localparam logic [DATA_WIDTH-1:0]  LEN_BYTE   = DATA_WIDTH'(PAYLOAD_LEN);

  logic [2:0]             state;
  logic [DATA_WIDTH-1:0]  checksum;
  logic [COUNT_WIDTH-1:0] byteCount;
  logic                   txFire;
  logic                   lastByte;

  assign txFire   = txValid & txReady;
  assign lastByte = (byteCount == LAST_INDEX);

  // Read strobe lasts exactly the one RD_REQ cycle; an empty FIFO holds it off
  always_comb begin
    fifoRdEn = 1'b0;
    if (state == RD_REQ && !fifoEmpty) begin
      fifoRdEn = 1'b1;
    end
  end

  // Busy whenever a frame is in progress
  always_comb begin
    busy = (state != IDLE);
  end

  // Frame FSM with registered output byte, valid/last, checksum and byte counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      txData    <= '0;
      txValid   <= 1'b0;
      txLast    <= 1'b0;
      checksum  <= '0;
      byteCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifoDataCount >= LEN_COUNT) begin
            state     <= HDR_SOF;
            txData    <= SOF_BYTE;
            txValid   <= 1'b1;
            txLast    <= 1'b0;
            checksum  <= '0;
            byteCount <= '0;
          end
        end

        HDR_SOF: begin
          if (txFire) begin
            state  <= HDR_LEN;
            txData <= LEN_BYTE;
          end
        end

        HDR_LEN: begin
          if (txFire) begin
            state   <= RD_REQ;
            txValid <= 1'b0;
          end
        end

        RD_REQ: begin
          if (!fifoEmpty) begin
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          state    <= PAYLOAD;
          txData   <= fifoRdData;
          txValid  <= 1'b1;
          checksum <= checksum + fifoRdData;
        end

        PAYLOAD: begin
          if (txFire) begin
            if (lastByte) begin
              state  <= CHKSUM;
              txData <= checksum;
              txLast <= 1'b1;
            end else begin
              state     <= RD_REQ;
              byteCount <= byteCount + 1'b1;
              txValid   <= 1'b0;
            end
          end
        end

        CHKSUM: begin
          if (txFire) begin
            state   <= IDLE;
            txValid <= 1'b0;
            txLast  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          txValid <= 1'b0;
          txLast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer
// Drives fifo_frame_packer from a small behavioural 8-deep FIFO with a
// registered read port. Expected frames are queued as payloads are written
// and popped by a monitor on every handshake.

module tb_fifo_frame_packer;

  logic       clk;
  logic       resetN;
  logic       fifoRdEn;
  logic [7:0] fifoRdData;
  logic       fifoEmpty;
  logic       fifoFull;
  logic [3:0] fifoDataCount;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       txLast;
  logic       busy;

  logic       wrEn;
  logic [7:0] wrData;

  int errors = 0;
  int checks = 0;

  logic [8:0] expQ[$];

  int         cycleCount = 0;
  int         rdPulses   = 0;
  logic       prevRdEn   = 1'b0;
  int         byteIdx    = 0;
  int         sofCycle   = 0;
  int         chkCycle   = 0;
  int         frameSpan  = 0;
  int         sofGap     = 0;
  logic [7:0] lastChk    = 8'h00;

  fifo_frame_packer #(
    .DATA_WIDTH (8),
    .COUNT_WIDTH(4),
    .PAYLOAD_LEN(4),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .fifoRdEn     (fifoRdEn),
    .fifoRdData   (fifoRdData),
    .fifoEmpty    (fifoEmpty),
    .fifoDataCount(fifoDataCount),
    .txData       (txData),
    .txValid      (txValid),
    .txReady      (txReady),
    .txLast       (txLast),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, count updated on the write/read edge
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic       doW, doR;
  assign doW           = wrEn && (fifoDataCount != 4'd8);
  assign doR           = fifoRdEn && (fifoDataCount != 4'd0);
  assign fifoEmpty     = (fifoDataCount == 4'd0);
  assign fifoFull      = (fifoDataCount == 4'd8);

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wp            <= '0;
      rp            <= '0;
      fifoDataCount <= '0;
      fifoRdData    <= '0;
    end else begin
      if (doW) begin
        mem[wp] <= wrData;
        wp      <= wp + 3'd1;
      end
      if (doR) begin
        fifoRdData <= mem[rp];
        rp         <= rp + 3'd1;
      end
      fifoDataCount <= fifoDataCount + 4'(doW) - 4'(doR);
    end
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: handshake scoreboard plus read-strobe accounting, sampled mid-cycle
  always @(negedge clk) begin
    if (resetN && fifoRdEn) begin
      rdPulses++;
      checkOutput("rdEnSingle", 32'(prevRdEn), 32'd0);
    end
    prevRdEn = fifoRdEn;
    if (resetN && txValid && txReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedByte", {23'd0, txLast, txData}, 32'h1FF);
      end else begin
        logic [8:0] e;
        e = expQ.pop_front();
        checkOutput("streamByte", {23'd0, txLast, txData}, {23'd0, e});
      end
      if (byteIdx == 0) begin
        sofGap   = cycleCount - chkCycle;
        sofCycle = cycleCount;
      end
      if (txLast) begin
        chkCycle  = cycleCount;
        frameSpan = chkCycle - sofCycle;
        lastChk   = txData;
        byteIdx   = 0;
      end else begin
        byteIdx++;
      end
    end
  end

  task automatic writeByte(input logic [7:0] b);
    wrEn   = 1'b1;
    wrData = b;
    @(posedge clk);
    #1;
    wrEn   = 1'b0;
  endtask

  // Queue the expected frame, then push the payload into the FIFO
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input bit writeLast = 1'b1);
    logic [7:0] p[4];
    logic [7:0] sum;
    p[0] = b0; p[1] = b1; p[2] = b2; p[3] = b3;
    sum = 8'h00;
    expQ.push_back({1'b0, 8'hA5});
    expQ.push_back({1'b0, 8'h04});
    for (int i = 0; i < 4; i++) begin
      expQ.push_back({1'b0, p[i]});
      sum = sum + p[i];
    end
    expQ.push_back({1'b1, sum});
    for (int i = 0; i < 3; i++) writeByte(p[i]);
    if (writeLast) writeByte(p[3]);
  endtask

  // Wait for the scoreboard to drain, bounded, then confirm the packer went idle
  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "Drained"}, 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "IdleBusy"}, {30'd0, busy, txValid}, 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    resetN = 1'b0;
    expQ.delete();
    byteIdx = 0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit active;
    int n;
    resetN  = 1'b0;
    txReady = 1'b1;
    wrEn    = 1'b0;
    wrData  = 8'h00;
    #1;
    // Reset values without any clock edge
    checkOutput("rstTxData",  32'(txData),   32'd0);
    checkOutput("rstTxValid", 32'(txValid),  32'd0);
    checkOutput("rstTxLast",  32'(txLast),   32'd0);
    checkOutput("rstRdEn",    32'(fifoRdEn), 32'd0);
    checkOutput("rstBusy",    32'(busy),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame
    $display("[TB] basic frame");
    rdPulses = 0;
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    waitDone("basic");
    checkOutput("basicRdPulses", 32'(rdPulses), 32'd4);
    checkOutput("basicEmpty",    32'(fifoEmpty), 32'd1);
    checkOutput("basicChk",      32'(lastChk), 32'hAA);

    // Below threshold, then the fourth byte starts a frame
    $display("[TB] below threshold");
    applyStimulus(8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
    active = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy || txValid || fifoRdEn) active = 1'b1;
    end
    checkOutput("belowIdle", 32'(active), 32'd0);
    @(posedge clk);
    #1;
    writeByte(8'h40);
    @(negedge clk);
    checkOutput("sofNotYet", 32'(txValid), 32'd0);
    @(negedge clk);
    checkOutput("sofValid", {23'd0, txValid, txData}, {23'd0, 1'b1, 8'hA5});
    waitDone("below");
    checkOutput("frameSpan", 32'(frameSpan), 32'd14);

    // Backpressure while byte 0x22 is presented
    $display("[TB] backpressure");
    rdPulses = 0;
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    n = 0;
    while (!(txValid && txData == 8'h22) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bpReach22", 32'(txData), 32'h22);
    txReady = 1'b0;
    active  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (txData != 8'h22 || !txValid || fifoRdEn) active = 1'b1;
    end
    checkOutput("bpHold", 32'(active), 32'd0);
    @(posedge clk);
    #1;
    txReady = 1'b1;
    waitDone("bp");
    checkOutput("bpRdPulses", 32'(rdPulses), 32'd4);

    // Checksum wrap
    $display("[TB] checksum wrap");
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'h03);
    waitDone("wrap");
    checkOutput("wrapChk", 32'(lastChk), 32'h00);

    // Reset mid-frame during payload byte 2
    $display("[TB] reset mid-frame");
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    n = 0;
    while (!(txValid && txData == 8'h33) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("midReach33", 32'(txData), 32'h33);
    resetN = 1'b0;
    expQ.delete();
    byteIdx = 0;
    #1;
    checkOutput("midRstOut", {27'd0, busy, fifoRdEn, txLast, txValid, |txData}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    checkOutput("midFifoCleared", 32'(fifoDataCount), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(8'h01, 8'h02, 8'h03, 8'h04);
    waitDone("afterRst");
    checkOutput("afterRstChk", 32'(lastChk), 32'h0A);

    // Back-to-back frames from a full FIFO
    $display("[TB] back-to-back");
    txReady  = 1'b0;
    rdPulses = 0;
    applyStimulus(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    applyStimulus(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    checkOutput("b2bFull", 32'(fifoFull), 32'd1);
    txReady = 1'b1;
    waitDone("b2b");
    checkOutput("b2bRdPulses", 32'(rdPulses), 32'd8);
    checkOutput("b2bCount",    32'(fifoDataCount), 32'd0);
    checkOutput("b2bGap",      32'(sofGap), 32'd2);

    doReset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_frame_packer.md
# fifo_frame_packer

Read-side consumer for the synchronous FIFO (`fifo`, 8-bit wide, depth 8). It waits until the FIFO holds a full payload, then drains exactly PAYLOAD_LEN bytes and emits them as a framed byte stream on a valid/ready interface. Each frame is SOF byte, length byte, payload bytes, then checksum byte. It sits directly downstream of `fifo` on the same clock and reset.

## Interface
- DATA_WIDTH, 8: byte width; fixed at 8, matching the FIFO width.
- COUNT_WIDTH, 4: width of `fifoDataCount`; holds 0..FIFO_DEPTH.
- PAYLOAD_LEN, 4: payload bytes per frame; legal range 1..8 (the FIFO depth).
- SOF_BYTE, 8'hA5: start-of-frame marker.

Ports:
- clk  in  1  rising-edge clock, shared with `fifo`.
- resetN  in  1  asynchronous, active-low reset, shared with `fifo`.
- fifoRdEn  out  1  FIFO read strobe; connects to the FIFO's `fifoRdEn`.
- fifoRdData  in  8  FIFO read data.
- fifoEmpty  in  1  FIFO empty flag.
- fifoDataCount  in  COUNT_WIDTH  FIFO occupancy.
- txData  out  8  output byte.
- txValid  out  1  `txData` is valid.
- txReady  in  1  downstream accepts the byte.
- txLast  out  1  high with the checksum byte only.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FIFO read latency.** The FIFO read is registered. `fifoRdData` is valid in the cycle after the edge that samples `fifoRdEn`=1.
- **States:** IDLE, HDR_SOF, HDR_LEN, RD_REQ, RD_WAIT, PAYLOAD, CHKSUM.
- **Handshake.** A transfer occurs on a rising edge where `txValid`=1 and `txReady`=1.
  - Once `txValid` rises, `txData` and `txLast` hold stable until that transfer.
  - `txValid` never drops without a transfer.
- **IDLE.** If `fifoDataCount` >= PAYLOAD_LEN: go to HDR_SOF. Register `txData`=SOF_BYTE and `txValid`=1. Clear the checksum and the byte counter.
- **HDR_SOF.** On transfer: go to HDR_LEN with `txData`=PAYLOAD_LEN.
- **HDR_LEN.** On transfer: go to RD_REQ with `txValid`=0.
- **RD_REQ.**
  - `fifoRdEn`=1 for exactly this one cycle, then go to RD_WAIT.
  - If `fifoEmpty`=1, hold in RD_REQ with `fifoRdEn`=0. This is a guard only and is unreachable in normal use.
- **RD_WAIT.** Capture `fifoRdData` into `txData`, set `txValid`=1, and add the byte to the checksum. Go to PAYLOAD.
- **PAYLOAD.** On transfer:
  - If byte counter = PAYLOAD_LEN-1: go to CHKSUM with `txData`=checksum and `txLast`=1.
  - Otherwise: increment the byte counter, set `txValid`=0, go to RD_REQ.
- **CHKSUM.** On transfer: go to IDLE with `txValid`=0 and `txLast`=0.
- **Checksum.** 8-bit sum of the payload bytes only, carry discarded (mod 256). SOF and length bytes are excluded.
- **One read per byte.** Exactly one `fifoRdEn` pulse per payload byte. Never more than PAYLOAD_LEN pulses per frame.
- **FIFO writes mid-frame.** Writes into the FIFO during a frame do not affect the current frame. Occupancy is only evaluated in IDLE.

## Timing
- **Reset values.** While `resetN`=0, immediately (no clock needed): `txData`=0, `txValid`=0, `txLast`=0, `fifoRdEn`=0, `busy`=0, state=IDLE, checksum=0, byte counter=0.
- **Reset mid-frame.** The partial frame is abandoned with no checksum and no `txLast`. The FIFO is cleared by the same `resetN`.
- **Frame timing with `txReady` held high.** Cycle 0 = the IDLE edge at which count >= PAYLOAD_LEN is seen.
  - SOF is valid in cycle 1.
  - LEN is valid in cycle 2.
  - Payload byte k (k=0..L-1) is valid in cycle 5+3k, with its `fifoRdEn` pulse in cycle 3+3k.
  - The checksum is valid in cycle 3L+3 (cycle 15 for L=4).
- **Back-to-back frames.** After the checksum transfer, one IDLE cycle follows. The next SOF is valid on the following cycle if occupancy still qualifies.
- **Backpressure.** Each cycle with `txReady`=0 while `txValid`=1 stretches the current state by one cycle. `fifoRdEn` stays low during those cycles.

## Test plan
- **Basic frame.** Reset, write 11,22,33,44, `txReady`=1.
  - Stream is A5,04,11,22,33,44,AA.
  - `txLast` is high only on AA.
  - Four single-cycle `fifoRdEn` pulses; `fifoEmpty`=1 afterward.
- **Below threshold.** Write only 3 bytes.
  - `busy`, `txValid` and `fifoRdEn` stay 0 for 50 cycles.
  - A 4th write starts a frame; the SOF is valid 2 cycles after the write edge.
- **Backpressure.** Drop `txReady` for 5 cycles while 22 is presented.
  - `txData` holds 22 with `txValid`=1.
  - No `fifoRdEn` pulse occurs during the stall.
  - The frame completes unchanged.
- **Checksum wrap.** Payload FF,FF,FF,03 produces checksum 00 with `txLast`=1.
- **Reset mid-frame.** Assert `resetN`=0 during PAYLOAD (byte 2).
  - All outputs are 0 before the next edge.
  - After release, writing 01,02,03,04 yields A5,04,01,02,03,04,0A.
- **Back-to-back.** Fill the FIFO with 8 bytes (`fifoFull`=1).
  - Two complete frames are emitted, separated by exactly one IDLE cycle.
  - Total of 8 `fifoRdEn` pulses; `fifoDataCount`=0 at the end.
